// File: rtl/card_pkg.sv
// Shared definitions for the card linked-list datapath: word field layout,
// deck geometry, list terminator and the builder FSM encoding.
package card_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  localparam int NUM_SUITS  = 4;
  localparam int NUM_VALUES = 13;
  localparam int NUM_CARDS  = NUM_SUITS * NUM_VALUES;

  localparam logic [ADDR_W-1:0] END_PTR = 10'h000;

  localparam int CARD_USED_BIT = 31;
  localparam int SUIT_MSB      = 21;
  localparam int SUIT_LSB      = 20;
  localparam int VALUE_MSB     = 19;
  localparam int VALUE_LSB     = 16;
  localparam int NEXT_MSB      = 9;
  localparam int NEXT_LSB      = 0;

  localparam logic [5:0]        LAST_INDEX  = 6'(NUM_CARDS - 1);
  localparam logic [3:0]        FIRST_VALUE = 4'd1;
  localparam logic [3:0]        LAST_VALUE  = 4'(NUM_VALUES);
  localparam logic [ADDR_W-1:0] MIN_BASE    = 10'd1;
  localparam logic [ADDR_W-1:0] MAX_BASE    = 10'(1024 - NUM_CARDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FINISH
  } build_state_t;

  // A deck must fit entirely above address 0 without wrapping past 1023.
  function automatic logic legal_base(input logic [ADDR_W-1:0] base);
    return (base >= MIN_BASE) && (base <= MAX_BASE);
  endfunction

endpackage

// File: rtl/deck_builder_if.sv
// Request/status handshake plus the RAM write port of the deck builder.
interface deck_builder_if;
  import card_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] head_addr;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;

  modport master (
    output start, base_addr,
    input  busy, done, error, head_addr, ram_address, ram_data, ram_wren
  );

  modport slave (
    input  start, base_addr,
    output busy, done, error, head_addr, ram_address, ram_data, ram_wren
  );

endinterface

// File: rtl/card_word_pack.sv
// Packs suit, value and next pointer into a 32-bit in-use card word.
module card_word_pack
  import card_pkg::*;
(
  input  logic [1:0]        suit,
  input  logic [3:0]        value,
  input  logic [ADDR_W-1:0] next_ptr,
  output logic [DATA_W-1:0] word
);

  // Drop each field into its slot; reserved bits stay zero.
  always_comb begin
    word                      = '0;
    word[CARD_USED_BIT]       = 1'b1;
    word[SUIT_MSB:SUIT_LSB]   = suit;
    word[VALUE_MSB:VALUE_LSB] = value;
    word[NEXT_MSB:NEXT_LSB]   = next_ptr;
  end

endmodule

// File: rtl/deck_builder.sv
// Writes a full ordered 52-card deck into card RAM as a singly linked list,
// one word per cycle, and reports the list head for downstream walkers.
module deck_builder
  import card_pkg::*;
(
  input  logic          clock,
  input  logic          resetn,
  deck_builder_if.slave ctrl
);

  build_state_t      state, state_n;
  logic [5:0]        index, index_n;
  logic [1:0]        suit, suit_n;
  logic [3:0]        value, value_n;
  logic [ADDR_W-1:0] head, head_n;
  logic              busy, busy_n;
  logic              done, done_n;
  logic              error, error_n;
  logic              wren, wren_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [DATA_W-1:0] data, data_n;
  logic [ADDR_W-1:0] next_ptr;
  logic [DATA_W-1:0] word;

  // Next-cycle control and write-port values; every output is computed one
  // cycle ahead so it can be registered with no path from start to ram_*.
  always_comb begin
    state_n = state;
    index_n = index;
    suit_n  = suit;
    value_n = value;
    head_n  = head;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    error_n = 1'b0;
    wren_n  = 1'b0;
    addr_n  = '0;
    unique case (state)
      ST_IDLE: begin
        if (ctrl.start) begin
          if (legal_base(ctrl.base_addr)) begin
            state_n = ST_WRITE;
            head_n  = ctrl.base_addr;
            index_n = '0;
            suit_n  = '0;
            value_n = FIRST_VALUE;
            busy_n  = 1'b1;
            wren_n  = 1'b1;
            addr_n  = ctrl.base_addr;
          end else begin
            error_n = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (index == LAST_INDEX) begin
          state_n = ST_FINISH;
          done_n  = 1'b1;
        end else begin
          index_n = index + 6'd1;
          if (value == LAST_VALUE) begin
            value_n = FIRST_VALUE;
            suit_n  = suit + 2'd1;
          end else begin
            value_n = value + 4'd1;
          end
          busy_n = 1'b1;
          wren_n = 1'b1;
          addr_n = head + {4'b0, index_n};
        end
      end
      ST_FINISH: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // The final card terminates the list; every other card points to its successor.
  always_comb begin
    next_ptr = (index_n == LAST_INDEX) ? END_PTR : addr_n + 10'd1;
    data_n   = wren_n ? word : '0;
  end

  card_word_pack u_pack (
    .suit     (suit_n),
    .value    (value_n),
    .next_ptr (next_ptr),
    .word     (word)
  );

  // State and registered outputs; reset abandons any partial list silently.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      index <= '0;
      suit  <= '0;
      value <= '0;
      head  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      wren  <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else begin
      state <= state_n;
      index <= index_n;
      suit  <= suit_n;
      value <= value_n;
      head  <= head_n;
      busy  <= busy_n;
      done  <= done_n;
      error <= error_n;
      wren  <= wren_n;
      addr  <= addr_n;
      data  <= data_n;
    end
  end

  assign ctrl.busy        = busy;
  assign ctrl.done        = done;
  assign ctrl.error       = error;
  assign ctrl.head_addr   = head;
  assign ctrl.ram_address = addr;
  assign ctrl.ram_data    = data;
  assign ctrl.ram_wren    = wren;

endmodule

// File: tb/tb_deck_builder.sv
// Self-checking bench for deck_builder: table of build/reject requests,
// then hand-written sequences for ignored starts, mid-build reset and
// back-to-back builds, with a RAM image walked as a linked list.
module tb_deck_builder;

  typedef struct {
    logic [9:0] base;
    bit         legal;
  } vector_t;

  logic clock = 1'b0;
  logic resetn;

  int checks     = 0;
  int failures   = 0;
  int wr_count   = 0;
  int done_count = 0;
  int zero_writes = 0;

  logic [31:0] ram [1024];
  logic [9:0]  expected_head;
  vector_t     vectors [7];

  deck_builder_if bus ();

  deck_builder dut (
    .clock  (clock),
    .resetn (resetn),
    .ctrl   (bus)
  );

  // Free-running 10 ns clock.
  always #5 clock = ~clock;

  // Capture every write into a RAM image and count writes and done pulses.
  always @(negedge clock) begin
    if (bus.ram_wren === 1'b1) begin
      ram[bus.ram_address] <= bus.ram_data;
      wr_count <= wr_count + 1;
      if (bus.ram_address == 10'd0) zero_writes <= zero_writes + 1;
    end
    if (bus.done === 1'b1) done_count <= done_count + 1;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] time limit");
  end

  function automatic logic [31:0] model_word(input int base, input int i);
    logic [1:0] s;
    logic [3:0] v;
    logic [9:0] n;
    s = 2'(i / 13);
    v = 4'((i % 13) + 1);
    n = (i == 51) ? 10'd0 : 10'(base + i + 1);
    return {1'b1, 9'd0, s, v, 6'd0, n};
  endfunction

  task automatic apply_stimulus(input logic start, input logic [9:0] base);
    bus.start     = start;
    bus.base_addr = base;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, " busy"}, 32'(bus.busy), 32'd0);
    check_output({tag, " done"}, 32'(bus.done), 32'd0);
    check_output({tag, " error"}, 32'(bus.error), 32'd0);
    check_output({tag, " wren"}, 32'(bus.ram_wren), 32'd0);
    check_output({tag, " addr"}, 32'(bus.ram_address), 32'd0);
    check_output({tag, " data"}, bus.ram_data, 32'd0);
  endtask

  // One accepted build, checked cycle by cycle; optionally pokes start mid-build.
  task automatic run_build(input logic [9:0] base, input bit poke_mid, input string tag);
    int wr_before;
    int done_before;
    @(negedge clock);
    wr_before   = wr_count;
    done_before = done_count;
    apply_stimulus(1'b1, base);
    @(negedge clock);
    apply_stimulus(1'b0, base);
    for (int k = 0; k < 52; k++) begin
      if (k > 0) @(negedge clock);
      check_output($sformatf("%s wren[%0d]", tag, k), 32'(bus.ram_wren), 32'd1);
      check_output($sformatf("%s busy[%0d]", tag, k), 32'(bus.busy), 32'd1);
      check_output($sformatf("%s addr[%0d]", tag, k), 32'(bus.ram_address),
                   32'(base) + 32'(k));
      check_output($sformatf("%s data[%0d]", tag, k), bus.ram_data,
                   model_word(int'(base), k));
      check_output($sformatf("%s done[%0d]", tag, k), 32'(bus.done), 32'd0);
      if (poke_mid) apply_stimulus((k == 4) || (k == 51), 10'd600);
    end
    @(negedge clock);
    apply_stimulus(1'b0, base);
    check_output({tag, " done pulse"}, 32'(bus.done), 32'd1);
    check_output({tag, " done wren"}, 32'(bus.ram_wren), 32'd0);
    check_output({tag, " done busy"}, 32'(bus.busy), 32'd0);
    check_output({tag, " head"}, 32'(bus.head_addr), 32'(base));
    expected_head = base;
    @(negedge clock);
    check_output({tag, " done drop"}, 32'(bus.done), 32'd0);
    check_output({tag, " idle wren"}, 32'(bus.ram_wren), 32'd0);
    check_output({tag, " write count"}, 32'(wr_count - wr_before), 32'd52);
    check_output({tag, " done count"}, 32'(done_count - done_before), 32'd1);
  endtask

  // One rejected request: error pulse, no writes, head untouched.
  task automatic run_reject(input logic [9:0] base, input string tag);
    int wr_before;
    @(negedge clock);
    wr_before = wr_count;
    apply_stimulus(1'b1, base);
    @(negedge clock);
    apply_stimulus(1'b0, base);
    check_output({tag, " error"}, 32'(bus.error), 32'd1);
    check_output({tag, " busy"}, 32'(bus.busy), 32'd0);
    check_output({tag, " wren"}, 32'(bus.ram_wren), 32'd0);
    check_output({tag, " head"}, 32'(bus.head_addr), 32'(expected_head));
    @(negedge clock);
    check_output({tag, " error drop"}, 32'(bus.error), 32'd0);
    check_output({tag, " write count"}, 32'(wr_count - wr_before), 32'd0);
  endtask

  // Follow next pointers from base through the captured RAM image.
  task automatic walk_list(input logic [9:0] base, input string tag);
    logic [9:0]  ptr;
    logic [31:0] w;
    int visits  = 0;
    int dups    = 0;
    int unused  = 0;
    int missing = 0;
    bit ended   = 1'b0;
    bit seen [4][16];
    for (int s = 0; s < 4; s++)
      for (int v = 0; v < 16; v++) seen[s][v] = 1'b0;
    ptr = base;
    for (int step = 0; step < 64 && !ended; step++) begin
      w = ram[ptr];
      if (w[31] !== 1'b1) unused++;
      if (seen[w[21:20]][w[19:16]]) dups++;
      seen[w[21:20]][w[19:16]] = 1'b1;
      visits++;
      if (w[9:0] == 10'd0) ended = 1'b1;
      else ptr = w[9:0];
    end
    for (int s = 0; s < 4; s++)
      for (int v = 1; v <= 13; v++) if (!seen[s][v]) missing++;
    check_output({tag, " walk visits"}, 32'(visits), 32'd52);
    check_output({tag, " walk dups"}, 32'(dups), 32'd0);
    check_output({tag, " walk missing"}, 32'(missing), 32'd0);
    check_output({tag, " walk unused"}, 32'(unused), 32'd0);
    check_output({tag, " walk end"}, 32'(ended), 32'd1);
  endtask

  initial begin
    int done_before;
    int phase;

    vectors[0] = '{base: 10'd100,  legal: 1'b1};
    vectors[1] = '{base: 10'd0,    legal: 1'b0};
    vectors[2] = '{base: 10'd973,  legal: 1'b0};
    vectors[3] = '{base: 10'd972,  legal: 1'b1};
    vectors[4] = '{base: 10'd1023, legal: 1'b0};
    vectors[5] = '{base: 10'd1,    legal: 1'b1};
    vectors[6] = '{base: 10'd500,  legal: 1'b1};

    resetn        = 1'b0;
    expected_head = 10'd0;
    apply_stimulus(1'b0, 10'd0);
    repeat (2) @(negedge clock);
    check_idle_outputs("reset");
    check_output("reset head", 32'(bus.head_addr), 32'd0);
    resetn = 1'b1;

    for (int v = 0; v < 7; v++) begin
      if (vectors[v].legal) begin
        run_build(vectors[v].base, 1'b0, $sformatf("vec%0d", v));
        walk_list(vectors[v].base, $sformatf("vec%0d", v));
      end else begin
        run_reject(vectors[v].base, $sformatf("vec%0d", v));
      end
    end

    check_output("ram[100]", ram[100], 32'h8001_0065);
    check_output("ram[112]", ram[112], 32'h800D_0071);
    check_output("ram[113]", ram[113], 32'h8011_0072);
    check_output("ram[151]", ram[151], 32'h803D_0000);
    check_output("ram[1023]", ram[1023], 32'h803D_0000);

    // start pulses during WRITE must be dropped without queueing or error.
    run_build(10'd300, 1'b1, "poke");
    walk_list(10'd300, "poke");
    repeat (3) @(negedge clock);
    check_output("poke no requeue", 32'(bus.ram_wren), 32'd0);
    check_output("poke no error", 32'(bus.error), 32'd0);
    check_output("poke head", 32'(bus.head_addr), 32'd300);

    // Asynchronous reset in the middle of a burst.
    @(negedge clock);
    apply_stimulus(1'b1, 10'd400);
    @(negedge clock);
    apply_stimulus(1'b0, 10'd400);
    repeat (20) @(negedge clock);
    check_output("mid wren", 32'(bus.ram_wren), 32'd1);
    check_output("mid addr", 32'(bus.ram_address), 32'd420);
    done_before = done_count;
    #2 resetn = 1'b0;
    #1;
    check_idle_outputs("async reset");
    check_output("async reset head", 32'(bus.head_addr), 32'd0);
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    expected_head = 10'd0;
    repeat (3) @(negedge clock);
    check_output("post reset done count", 32'(done_count - done_before), 32'd0);
    check_idle_outputs("post reset");
    run_build(10'd200, 1'b0, "rebuild");
    walk_list(10'd200, "rebuild");

    // start held high: back-to-back builds, one idle cycle after each done.
    @(negedge clock);
    apply_stimulus(1'b1, 10'd1);
    @(negedge clock);
    for (int c = 0; c < 162; c++) begin
      if (c > 0) @(negedge clock);
      phase = c % 54;
      if (phase < 52) begin
        check_output($sformatf("held wren[%0d]", c), 32'(bus.ram_wren), 32'd1);
        check_output($sformatf("held addr[%0d]", c), 32'(bus.ram_address),
                     32'(1 + phase));
        check_output($sformatf("held data[%0d]", c), bus.ram_data, model_word(1, phase));
      end else if (phase == 52) begin
        check_output($sformatf("held done[%0d]", c), 32'(bus.done), 32'd1);
        check_output($sformatf("held wren[%0d]", c), 32'(bus.ram_wren), 32'd0);
      end else begin
        check_output($sformatf("held gap wren[%0d]", c), 32'(bus.ram_wren), 32'd0);
        check_output($sformatf("held gap busy[%0d]", c), 32'(bus.busy), 32'd0);
        check_output($sformatf("held gap done[%0d]", c), 32'(bus.done), 32'd0);
      end
      if (c == 2 * 54 + 52) apply_stimulus(1'b0, 10'd1);
    end
    @(negedge clock);
    check_output("held stop wren", 32'(bus.ram_wren), 32'd0);
    check_output("held head", 32'(bus.head_addr), 32'd1);
    walk_list(10'd1, "held");

    check_output("writes to address 0", 32'(zero_writes), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
